// File: rtl/spi_pkg.sv
// Shared definitions for the SPI chip-select sequencer.
//   state_t     : sequencer FSM states
//   count_width : bits needed to hold the values 0..n
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ISSUE,
    WAIT_RX,
    WAIT_NEXT,
    HOLD,
    INACTIVE
  } state_t;

  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spi_cs_sequencer_if.sv
// Byte handshake bundle between host, sequencer and SPI_Master.
//   host side   : i_TX_Count, i_TX_Byte, i_TX_DV -> ; <- o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte
//   master side : <- o_M_TX_Byte, o_M_TX_DV ; i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte ->
//   chip select : o_SPI_CS_n (active low)
// The slave modport is the sequencer's view; master is the driver/bench view.
interface spi_cs_sequencer_if #(
  parameter int CW = 3
);
  logic [CW-1:0] i_TX_Count;
  logic [7:0]    i_TX_Byte;
  logic          i_TX_DV;
  logic          o_TX_Ready;
  logic [CW-1:0] o_RX_Count;
  logic          o_RX_DV;
  logic [7:0]    o_RX_Byte;
  logic [7:0]    o_M_TX_Byte;
  logic          o_M_TX_DV;
  logic          i_M_TX_Ready;
  logic          i_M_RX_DV;
  logic [7:0]    i_M_RX_Byte;
  logic          o_SPI_CS_n;

  modport slave (
    input  i_TX_Count, i_TX_Byte, i_TX_DV, i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
    output o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte, o_M_TX_Byte, o_M_TX_DV, o_SPI_CS_n
  );

  modport master (
    output i_TX_Count, i_TX_Byte, i_TX_DV, i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
    input  o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte, o_M_TX_Byte, o_M_TX_DV, o_SPI_CS_n
  );

endinterface

// File: rtl/spi_cs_sequencer.sv
// Chip-select sequencer in front of SPI_Master. Frames 1..MAX_BYTES_PER_CS
// host bytes under one CS-low window with setup/hold/inactive spacing, and
// returns each received byte with its 1-based index.
//   i_Clk, i_Rst : clock, asynchronous active-high reset
//   bus (slave)  : host byte stream, SPI_Master handshake, o_SPI_CS_n
// All outputs are registered.
module spi_cs_sequencer
  import spi_pkg::*;
#(
  parameter int MAX_BYTES_PER_CS = 4,
  parameter int CS_SETUP_CLKS    = 2,
  parameter int CS_HOLD_CLKS     = 2,
  parameter int CS_INACTIVE_CLKS = 4,
  parameter int CW               = count_width(MAX_BYTES_PER_CS)
) (
  input logic               i_Clk,
  input logic               i_Rst,
  spi_cs_sequencer_if.slave bus
);

  localparam int DLY_MAX =
    (CS_SETUP_CLKS > CS_HOLD_CLKS)
      ? ((CS_SETUP_CLKS > CS_INACTIVE_CLKS) ? CS_SETUP_CLKS : CS_INACTIVE_CLKS)
      : ((CS_HOLD_CLKS  > CS_INACTIVE_CLKS) ? CS_HOLD_CLKS  : CS_INACTIVE_CLKS);
  localparam int DW = count_width(DLY_MAX);

  // Delay counter is loaded with N-1 on entry, so a phase lasts exactly N cycles.
  localparam logic [DW-1:0] SETUP_LD = DW'(CS_SETUP_CLKS - 1);
  localparam logic [DW-1:0] HOLD_LD  = DW'(CS_HOLD_CLKS - 1);
  localparam logic [DW-1:0] INACT_LD = DW'(CS_INACTIVE_CLKS - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_BYTES_PER_CS);

  state_t        state;
  logic [DW-1:0] dly;
  logic [CW-1:0] remaining;
  logic [CW-1:0] req_cnt;
  logic          accept;

  logic          tx_ready, m_tx_dv, rx_dv, cs_n;
  logic [7:0]    m_tx_byte, rx_byte;
  logic [CW-1:0] rx_count;

  assign accept  = bus.i_TX_DV & tx_ready;
  // A zero count still means one byte; oversize counts clamp to the window size.
  assign req_cnt = (bus.i_TX_Count == '0)     ? CW'(1)  :
                   (bus.i_TX_Count > MAX_CNT) ? MAX_CNT : bus.i_TX_Count;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state     <= IDLE;
      dly       <= '0;
      remaining <= '0;
      tx_ready  <= 1'b0;
      m_tx_dv   <= 1'b0;
      rx_dv     <= 1'b0;
      cs_n      <= 1'b1;
      m_tx_byte <= '0;
      rx_byte   <= '0;
      rx_count  <= '0;
    end else begin
      m_tx_dv  <= 1'b0;
      rx_dv    <= 1'b0;
      tx_ready <= 1'b0;
      case (state)
        IDLE: begin
          tx_ready <= 1'b1;
          if (accept) begin
            m_tx_byte <= bus.i_TX_Byte;
            remaining <= req_cnt;
            rx_count  <= '0;
            dly       <= SETUP_LD;
            cs_n      <= 1'b0;
            tx_ready  <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          // Issue straight from the last setup cycle so CS-to-TX_DV is exactly
          // CS_SETUP_CLKS; fall back to ISSUE if the master is still busy.
          if (dly != '0) begin
            dly <= dly - DW'(1);
          end else if (bus.i_M_TX_Ready) begin
            m_tx_dv   <= 1'b1;
            remaining <= (remaining != '0) ? remaining - CW'(1) : '0;
            state     <= WAIT_RX;
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.i_M_TX_Ready) begin
            m_tx_dv   <= 1'b1;
            remaining <= (remaining != '0) ? remaining - CW'(1) : '0;
            state     <= WAIT_RX;
          end
        end
        WAIT_RX: begin
          if (bus.i_M_RX_DV) begin
            rx_dv    <= 1'b1;
            rx_byte  <= bus.i_M_RX_Byte;
            rx_count <= (rx_count != MAX_CNT) ? rx_count + CW'(1) : rx_count;
            if (remaining != '0) begin
              tx_ready <= bus.i_M_TX_Ready;
              state    <= WAIT_NEXT;
            end else begin
              dly   <= HOLD_LD;
              state <= HOLD;
            end
          end
        end
        WAIT_NEXT: begin
          // No timeout: CS stays low until the host supplies the next byte.
          if (accept) begin
            m_tx_byte <= bus.i_TX_Byte;
            state     <= ISSUE;
          end else begin
            tx_ready <= bus.i_M_TX_Ready;
          end
        end
        HOLD: begin
          if (dly != '0) begin
            dly <= dly - DW'(1);
          end else begin
            cs_n  <= 1'b1;
            dly   <= INACT_LD;
            state <= INACTIVE;
          end
        end
        INACTIVE: begin
          if (dly != '0) begin
            dly <= dly - DW'(1);
          end else begin
            tx_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          cs_n  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_TX_Ready  = tx_ready;
  assign bus.o_M_TX_DV   = m_tx_dv;
  assign bus.o_M_TX_Byte = m_tx_byte;
  assign bus.o_RX_DV     = rx_dv;
  assign bus.o_RX_Byte   = rx_byte;
  assign bus.o_RX_Count  = rx_count;
  assign bus.o_SPI_CS_n  = cs_n;

endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Bench for spi_cs_sequencer. A cycle-level SPI_Master stand-in (mode 3,
// CLKS_PER_HALF_BIT=4, MOSI looped to MISO, so each byte returns unchanged
// 64 clocks after o_M_TX_DV) sits on the master side. Expected RX bytes and
// indices are queued when the host byte is driven and popped on o_RX_DV.
module tb_spi_cs_sequencer;

  localparam int MAXB      = 4;
  localparam int P_SETUP   = 2;
  localparam int P_HOLD    = 2;
  localparam int P_INACT   = 4;
  localparam int CW        = spi_pkg::count_width(MAXB);
  localparam int BYTE_CLKS = 2 * 4 * 8;

  typedef struct packed {
    logic [7:0]    b;
    logic [CW-1:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_model = 1'b1;
  always #5 clk = ~clk;

  spi_cs_sequencer_if #(.CW(CW)) bus ();

  spi_cs_sequencer #(
    .MAX_BYTES_PER_CS(MAXB),
    .CS_SETUP_CLKS   (P_SETUP),
    .CS_HOLD_CLKS    (P_HOLD),
    .CS_INACTIVE_CLKS(P_INACT),
    .CW              (CW)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (bus.slave)
  );

  // SPI_Master stand-in; has its own reset so it keeps shifting when the
  // sequencer alone is reset mid-byte.
  logic [7:0] m_sh;
  int         m_busy;
  always @(posedge clk or posedge rst_model) begin
    if (rst_model) begin
      bus.i_M_TX_Ready <= 1'b1;
      bus.i_M_RX_DV    <= 1'b0;
      bus.i_M_RX_Byte  <= 8'h00;
      m_sh             <= 8'h00;
      m_busy           <= 0;
    end else begin
      bus.i_M_RX_DV <= 1'b0;
      if (bus.i_M_TX_Ready && bus.o_M_TX_DV) begin
        bus.i_M_TX_Ready <= 1'b0;
        m_sh             <= bus.o_M_TX_Byte;
        m_busy           <= BYTE_CLKS;
      end else if (!bus.i_M_TX_Ready) begin
        if (m_busy <= 1) begin
          bus.i_M_RX_DV    <= 1'b1;
          bus.i_M_RX_Byte  <= m_sh;
          bus.i_M_TX_Ready <= 1'b1;
        end
        m_busy <= m_busy - 1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   t_acc, t_fall, t_rise, t_mtx, t_mrx, t_rdy;
  int   n_fall, n_rise, n_mtx;
  logic prev_cs  = 1'b1;
  logic prev_rdy = 1'b0;
  exp_t mon_e;

  // Event monitor: edge timestamps (in cycles) and the RX scoreboard.
  initial forever begin
    @(negedge clk);
    if (prev_cs && !bus.o_SPI_CS_n) begin n_fall++; t_fall = cyc; end
    if (!prev_cs && bus.o_SPI_CS_n) begin n_rise++; t_rise = cyc; end
    if (!prev_rdy && bus.o_TX_Ready) t_rdy = cyc;
    prev_cs  = bus.o_SPI_CS_n;
    prev_rdy = bus.o_TX_Ready;
    if (bus.i_M_RX_DV) t_mrx = cyc;
    if (bus.o_M_TX_DV) begin
      n_mtx++;
      t_mtx = cyc;
      checks++;
      if (bus.i_M_TX_Ready !== 1'b1) begin
        errors++;
        $display("FAIL m_tx_dv_while_busy: master ready=%b, required 1", bus.i_M_TX_Ready);
      end
    end
    if (bus.o_RX_DV) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected: got byte %h idx %0d, required no pulse", bus.o_RX_Byte, bus.o_RX_Count);
      end else begin
        mon_e = sb.pop_front();
        if (bus.o_RX_Byte !== mon_e.b || bus.o_RX_Count !== mon_e.idx) begin
          errors++;
          $display("FAIL rx_data: got %h/%0d, required %h/%0d", bus.o_RX_Byte, bus.o_RX_Count, mon_e.b, mon_e.idx);
        end
      end
    end
  end

  task automatic clear_stats();
    n_fall = 0; n_rise = 0; n_mtx = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int cnt, input int idx);
    int   w = 0;
    exp_t ent;
    @(negedge clk);
    while (bus.o_TX_Ready !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
    checks++;
    if (w >= 1000) begin
      errors++;
      $display("FAIL send_timeout: ready=%b, required 1 within 1000 cycles", bus.o_TX_Ready);
    end else begin
      bus.i_TX_Byte  = b;
      bus.i_TX_Count = CW'(cnt);
      bus.i_TX_DV    = 1'b1;
      t_acc          = cyc;
      ent.b          = b;
      ent.idx        = CW'(idx);
      sb.push_back(ent);
      @(negedge clk);
      bus.i_TX_DV = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int w = 0;
    @(negedge clk);
    while (!(bus.o_SPI_CS_n === 1'b1 && bus.o_TX_Ready === 1'b1) && w < 2000) begin
      @(negedge clk); w++;
    end
    checks++;
    if (w >= 2000) begin
      errors++;
      $display("FAIL %s_idle_timeout: cs_n=%b ready=%b, required 1/1", name, bus.o_SPI_CS_n, bus.o_TX_Ready);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.o_SPI_CS_n !== 1'b1 || bus.o_TX_Ready !== 1'b0 || bus.o_M_TX_DV !== 1'b0 || bus.o_RX_DV !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: cs_n/rdy/mtxdv/rxdv=%b%b%b%b, required 1000",
               bus.o_SPI_CS_n, bus.o_TX_Ready, bus.o_M_TX_DV, bus.o_RX_DV);
    end
    checks++;
    if (bus.o_M_TX_Byte !== 8'h00 || bus.o_RX_Byte !== 8'h00 || bus.o_RX_Count !== '0) begin
      errors++;
      $display("FAIL reset_data: mtx=%h rx=%h cnt=%0d, required 00 00 0", bus.o_M_TX_Byte, bus.o_RX_Byte, bus.o_RX_Count);
    end
    rst_model = 1'b0;
    rst       = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.o_TX_Ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ready=%b, required 1", bus.o_TX_Ready);
    end
  endtask

  task automatic test_single();
    clear_stats();
    send_byte(8'hC1, 1, 1);
    wait_idle("single");
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL single_rx_missing: pending=%0d, required 0", sb.size()); end
    checks++;
    if (n_fall != 1 || n_rise != 1 || n_mtx != 1) begin
      errors++;
      $display("FAIL single_counts: fall/rise/mtx=%0d/%0d/%0d, required 1/1/1", n_fall, n_rise, n_mtx);
    end
    checks++;
    if (t_fall - t_acc != 1) begin errors++; $display("FAIL single_cs_fall: %0d cycles, required 1", t_fall - t_acc); end
    checks++;
    if (t_mtx - t_fall != P_SETUP) begin errors++; $display("FAIL single_setup: %0d cycles, required %0d", t_mtx - t_fall, P_SETUP); end
    // t_mrx is the cycle the master pulse is visible; the sequencer samples it
    // at the closing edge, and CS stays low P_HOLD cycles after that edge.
    checks++;
    if (t_rise - t_mrx != P_HOLD + 1) begin errors++; $display("FAIL single_hold: %0d cycles, required %0d", t_rise - t_mrx, P_HOLD + 1); end
    checks++;
    if (t_rdy - t_rise != P_INACT) begin errors++; $display("FAIL single_inactive: %0d cycles, required %0d", t_rdy - t_rise, P_INACT); end
  endtask

  task automatic test_multi();
    clear_stats();
    send_byte(8'hBE, 3, 1);
    send_byte(8'hEF, 0, 2);   // count changes after acceptance must not matter
    send_byte(8'h55, 1, 3);
    wait_idle("multi");
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL multi_rx_missing: pending=%0d, required 0", sb.size()); end
    checks++;
    if (n_fall != 1 || n_rise != 1 || n_mtx != 3) begin
      errors++;
      $display("FAIL multi_counts: fall/rise/mtx=%0d/%0d/%0d, required 1/1/3", n_fall, n_rise, n_mtx);
    end
  endtask

  task automatic test_count_zero();
    clear_stats();
    send_byte(8'hA5, 0, 1);
    wait_idle("zero");
    checks++;
    if (sb.size() != 0 || n_mtx != 1 || n_rise != 1) begin
      errors++;
      $display("FAIL zero_count: pending=%0d mtx=%0d rise=%0d, required 0/1/1", sb.size(), n_mtx, n_rise);
    end
  endtask

  task automatic test_clamp();
    clear_stats();
    for (int i = 1; i <= MAXB; i++) send_byte(8'(8'h10 + i), 7, i);
    wait_idle("clamp");
    checks++;
    if (sb.size() != 0 || n_mtx != MAXB || n_fall != 1 || n_rise != 1) begin
      errors++;
      $display("FAIL clamp: pending=%0d mtx=%0d fall=%0d rise=%0d, required 0/%0d/1/1", sb.size(), n_mtx, n_fall, n_rise, MAXB);
    end
  endtask

  task automatic test_drop();
    int w;
    clear_stats();
    send_byte(8'h11, 1, 1);
    // Now in SETUP.
    checks++;
    if (bus.o_TX_Ready !== 1'b0) begin errors++; $display("FAIL drop_setup_ready: ready=%b, required 0", bus.o_TX_Ready); end
    bus.i_TX_Byte = 8'hEE; bus.i_TX_Count = CW'(2); bus.i_TX_DV = 1'b1;
    @(negedge clk); bus.i_TX_DV = 1'b0;
    w = 0;
    while (bus.o_RX_DV !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
    checks++;
    if (w >= 1000) begin errors++; $display("FAIL drop_rx_timeout: rx_dv=%b, required 1", bus.o_RX_DV); end
    // o_RX_DV visible means the sequencer is in HOLD.
    checks++;
    if (bus.o_TX_Ready !== 1'b0) begin errors++; $display("FAIL drop_hold_ready: ready=%b, required 0", bus.o_TX_Ready); end
    bus.i_TX_DV = 1'b1;
    @(negedge clk); bus.i_TX_DV = 1'b0;
    w = 0;
    while (bus.o_SPI_CS_n !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    checks++;
    if (w >= 100 || bus.o_TX_Ready !== 1'b0) begin
      errors++;
      $display("FAIL drop_inactive: cs_n=%b ready=%b, required 1/0", bus.o_SPI_CS_n, bus.o_TX_Ready);
    end
    bus.i_TX_DV = 1'b1;
    @(negedge clk); bus.i_TX_DV = 1'b0;
    wait_idle("drop");
    checks++;
    if (sb.size() != 0 || n_mtx != 1 || n_fall != 1 || n_rise != 1) begin
      errors++;
      $display("FAIL drop_counts: pending=%0d mtx=%0d fall=%0d rise=%0d, required 0/1/1/1", sb.size(), n_mtx, n_fall, n_rise);
    end
  endtask

  task automatic test_stall();
    int w = 0;
    int cs_high = 0;
    clear_stats();
    send_byte(8'hA1, 2, 1);
    while (bus.o_TX_Ready !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
    checks++;
    if (w >= 1000) begin errors++; $display("FAIL stall_next_timeout: ready=%b, required 1", bus.o_TX_Ready); end
    repeat (50) begin
      @(negedge clk);
      if (bus.o_SPI_CS_n !== 1'b0) cs_high++;
    end
    checks++;
    if (cs_high != 0 || n_mtx != 1) begin
      errors++;
      $display("FAIL stall_hold_low: cs_high_cycles=%0d mtx=%0d, required 0/1", cs_high, n_mtx);
    end
    send_byte(8'hA2, 2, 2);
    wait_idle("stall");
    checks++;
    if (sb.size() != 0 || n_mtx != 2 || n_fall != 1 || n_rise != 1) begin
      errors++;
      $display("FAIL stall_counts: pending=%0d mtx=%0d fall=%0d rise=%0d, required 0/2/1/1", sb.size(), n_mtx, n_fall, n_rise);
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    clear_stats();
    send_byte(8'h77, 1, 1);
    while (n_mtx == 0 && w < 100) begin @(negedge clk); w++; end
    checks++;
    if (w >= 100) begin errors++; $display("FAIL rmid_issue_timeout: mtx=%0d, required 1", n_mtx); end
    repeat (10) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bus.o_SPI_CS_n !== 1'b1 || bus.o_TX_Ready !== 1'b0 || bus.o_M_TX_DV !== 1'b0 || bus.o_RX_DV !== 1'b0) begin
      errors++;
      $display("FAIL rmid_ctrl: cs_n/rdy/mtxdv/rxdv=%b%b%b%b, required 1000",
               bus.o_SPI_CS_n, bus.o_TX_Ready, bus.o_M_TX_DV, bus.o_RX_DV);
    end
    checks++;
    if (bus.o_M_TX_Byte !== 8'h00 || bus.o_RX_Byte !== 8'h00 || bus.o_RX_Count !== '0) begin
      errors++;
      $display("FAIL rmid_data: mtx=%h rx=%h cnt=%0d, required 00 00 0", bus.o_M_TX_Byte, bus.o_RX_Byte, bus.o_RX_Count);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_stats();
    // The master is still shifting 0x77; its late RX pulse must be ignored.
    send_byte(8'h3C, 1, 1);
    wait_idle("rmid");
    checks++;
    if (sb.size() != 0 || n_mtx != 1 || n_fall != 1 || n_rise != 1) begin
      errors++;
      $display("FAIL rmid_after: pending=%0d mtx=%0d fall=%0d rise=%0d, required 0/1/1/1", sb.size(), n_mtx, n_fall, n_rise);
    end
  endtask

  initial begin
    bus.i_TX_DV    = 1'b0;
    bus.i_TX_Byte  = 8'h00;
    bus.i_TX_Count = '0;
    test_reset();
    test_single();
    test_multi();
    test_count_zero();
    test_clamp();
    test_drop();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
